// File: rtl/sram_req_ctrl_if.sv
// Request/response bundle between a requester and the SRAM request controller.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the response channel.
interface sram_req_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;

    // Requester side.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_req_ctrl.sv
// Generic first-word-fall-through FIFO with occupancy count; output data is 0 when empty.
// Latency: a pushed word is visible at the output the cycle after the push.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_vld,
    input  logic [WIDTH-1:0]               push_dat,
    input  logic                           pop_rdy,
    output logic                           pop_vld,
    output logic [WIDTH-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign do_pop  = pop_rdy && pop_vld;
    assign do_push = push_vld && ((count != CNT_W'(DEPTH)) || do_pop);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    // Storage needs no reset: the gated output hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// SRAM port-0 request controller: drives the macro combinationally on accept, returns reads in order.
// Latency: read accepted in cycle N has its data captured at end of N+1, response valid from N+2.
// Backpressure: 3 response credits (FIFO entries + read in flight); req_ready is registered-state only.
// Build option SRAM_REQ_CTRL_WR_ACK_EN: writes also return a zero-data response and use a credit.
module sram_req_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clk0,
    input  logic                 rst_n,
    sram_req_ctrl_if.slave       bus,
    output logic                 csb0,
    output logic                 web0,
    output logic [DATA_W/8-1:0]  wmask0,
    output logic [ADDR_W-1:0]    addr0,
    output logic [DATA_W-1:0]    din0,
    input  logic [DATA_W-1:0]    dout0
);
    localparam int DEPTH = 3;

    logic              ready_en_q;
    logic              inflight_q;
    logic              accept;
    logic              rsp_gen;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] push_dat;

    // Credits are counted from flops only, so req_ready never depends on req_valid or rsp_ready.
    assign bus.req_ready = ready_en_q && (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd3);
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef SRAM_REQ_CTRL_WR_ACK_EN
    logic inflight_wr_q;

    assign rsp_gen  = 1'b1;
    assign push_dat = inflight_wr_q ? '0 : dout0;

    // Remember whether the in-flight entry is a write acknowledge (zero data).
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            inflight_wr_q <= 1'b0;
        end else begin
            inflight_wr_q <= accept && bus.req_we;
        end
    end
`else
    assign rsp_gen  = !bus.req_we;
    assign push_dat = dout0;
`endif

    // Ready comes up one edge after reset release; inflight marks the macro access cycle.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            inflight_q <= accept && rsp_gen;
        end
    end

    // Macro pins follow the request only in an accept cycle, otherwise idle values.
    always_comb begin
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        if (accept) begin
            csb0   = 1'b0;
            web0   = !bus.req_we;
            wmask0 = bus.req_wmask;
            addr0  = bus.req_addr;
            din0   = bus.req_wdata;
        end
    end

    fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk      (clk0),
        .rst_n    (rst_n),
        .push_vld (inflight_q),
        .push_dat (push_dat),
        .pop_rdy  (bus.rsp_ready),
        .pop_vld  (bus.rsp_valid),
        .pop_dat  (bus.rsp_rdata),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: directed scenarios plus random traffic against a
// reference memory and an expected-response queue with accept-cycle timestamps.
// Honours SRAM_REQ_CTRL_WR_ACK_EN in the same way as the design.
module tb_sram_req_ctrl;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk0 = 1'b0;
    logic        rst_n;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 32'h0;

    sram_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk0   (clk0),
        .rst_n  (rst_n),
        .bus    (bus),
        .csb0   (csb0),
        .web0   (web0),
        .wmask0 (wmask0),
        .addr0  (addr0),
        .din0   (din0),
        .dout0  (dout0)
    );

    always #5 clk0 = ~clk0;

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Behavioural single-port SRAM macro: registered read, byte-masked write.
    logic [31:0] sram_mem [512];
    bit          sram_init = 1'b0;
    always @(posedge clk0) begin
        if (!sram_init) begin
            for (int i = 0; i < 512; i++) sram_mem[i] <= init_word(i);
            sram_init <= 1'b1;
        end else if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wmask0[b]) sram_mem[addr0][8*b +: 8] <= din0[8*b +: 8];
            end else begin
                dout0 <= sram_mem[addr0];
            end
        end
    end

    // Reference state.
    logic [31:0] ref_mem [512];
    exp_t        exp_q [$];
    bit          ready_ok = 1'b0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_rsp = 0;
    logic [31:0] last_rsp = 32'h0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [8:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
    endtask

    // One clock cycle: check every output against the model, then advance the model.
    task automatic tick();
        logic        exp_rdy;
        logic        acc;
        logic        exp_vld;
        logic [31:0] exp_dat;
        exp_t        e;
        #1;
        exp_rdy = ready_ok && (exp_q.size() < 3);
        acc     = bus.req_valid && exp_rdy;
        exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        exp_dat = exp_vld ? exp_q[0].dat : 32'h0;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("csb0", csb0, !acc);
        chk("web0", web0, acc ? !bus.req_we : 1'b1);
        chk("addr0", addr0, acc ? bus.req_addr : 9'h0);
        chk("din0", din0, acc ? bus.req_wdata : 32'h0);
        chk("wmask0", wmask0, acc ? bus.req_wmask : 4'h0);
        chk("rsp_valid", bus.rsp_valid, exp_vld);
        chk("rsp_rdata", bus.rsp_rdata, exp_dat);
        if (exp_vld && bus.rsp_ready) begin
            e = exp_q.pop_front();
            last_rsp = e.dat;
            n_rsp++;
        end
        if (acc) begin
            n_acc++;
            if (bus.req_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.req_wmask[b]) ref_mem[bus.req_addr][8*b +: 8] = bus.req_wdata[8*b +: 8];
`ifdef SRAM_REQ_CTRL_WR_ACK_EN
                e.dat = 32'h0;
                e.cyc = cyc;
                exp_q.push_back(e);
`endif
            end else begin
                e.dat = ref_mem[bus.req_addr];
                e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
        @(posedge clk0);
        cyc++;
        @(negedge clk0);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int base;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
        rst_n         = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 9'h0, 32'h0, 4'h0);

        // Reset values, then release; ready rises on the first edge after release.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ready_ok = 1'b1;
        bus.rsp_ready = 1'b1;
        idle(2);

        // Write then read back the same word.
        drive(1'b1, 1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
        #1;
        chk("w028_csb0", csb0, 1'b0);
        chk("w028_web0", web0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 9'h005, 32'h0, 4'h0);
        base = n_rsp;
        tick();
        idle(4);
        chk("w028_nrsp", n_rsp - base, 1);
        chk("w028_data", last_rsp, 32'hDEADBEEF);

        // Partial byte-mask overwrite.
        drive(1'b1, 1'b1, 9'h010, 32'h11223344, 4'hF);
        tick();
        drive(1'b1, 1'b1, 9'h010, 32'hAABBCCDD, 4'h5);
        tick();
        drive(1'b1, 1'b0, 9'h010, 32'h0, 4'h0);
        tick();
        idle(4);
        chk("w029_data", last_rsp, 32'h11BB33DD);

        // Back-to-back reads at full rate.
        base = n_acc;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 9'(i), 32'h0, 4'h0);
            tick();
        end
        chk("r030_accepts", n_acc - base, 8);
        idle(4);
        chk("r030_drained", exp_q.size(), 0);
        chk("r030_last", last_rsp, init_word(7));

        // Stall responses: exactly three credits, then drain in order.
        bus.rsp_ready = 1'b0;
        base = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 9'(9'h020 + i), 32'h0, 4'h0);
            tick();
        end
        chk("r031_accepts", n_acc - base, 3);
        #1;
        chk("r031_ready", bus.req_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        base = n_rsp;
        idle(6);
        chk("r031_drain", n_rsp - base, 3);
        chk("r031_last", last_rsp, init_word(9'h022));

        // Write followed by read: response count depends on write acknowledges.
        base = n_rsp;
        drive(1'b1, 1'b1, 9'h040, 32'hCAFEF00D, 4'hF);
        tick();
        drive(1'b1, 1'b0, 9'h040, 32'h0, 4'h0);
        tick();
        idle(5);
`ifdef SRAM_REQ_CTRL_WR_ACK_EN
        chk("r033_nrsp", n_rsp - base, 2);
`else
        chk("r033_nrsp", n_rsp - base, 1);
`endif
        chk("r033_data", last_rsp, 32'hCAFEF00D);

        // Reset in the cycle after a read accept discards the read.
        drive(1'b1, 1'b0, 9'h033, 32'h0, 4'h0);
        tick();
        rst_n    = 1'b0;
        ready_ok = 1'b0;
        exp_q.delete();
        #1;
        chk("r032_csb0", csb0, 1'b1);
        chk("r032_rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        tick();
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        ready_ok = 1'b1;
        base = n_rsp;
        idle(5);
        chk("r032_nrsp", n_rsp - base, 0);

        // Random traffic over a small address window to provoke read-after-write hits.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  9'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            bus.rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        idle(8);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
